// File: rtl/berger_pkg.sv
// Shared Berger-code definitions: field widths, the stage-2 payload type and
// a reference encoder for the producer side of the link.
package berger_pkg;

    localparam int BERGER_DATA_W    = 8;
    localparam int BERGER_CHECK_W   = 4;
    localparam int BERGER_CODE_W    = 12;
    localparam int BERGER_ERR_CNT_W = 16;

    // A clean word has ones(data) + check equal to the data width.
    localparam logic [BERGER_CHECK_W:0] BERGER_SUM_OK = 5'd8;

    typedef struct packed {
        logic [BERGER_DATA_W-1:0] data;
        logic                     err;
    } berger_s2_t;

    // Check field = number of zeros in the data byte.
    function automatic logic [BERGER_CODE_W-1:0] berger_encode(input logic [BERGER_DATA_W-1:0] d);
        logic [BERGER_CHECK_W-1:0] zeros;
        zeros = '0;
        for (int i = 0; i < BERGER_DATA_W; i++)
            zeros = zeros + {{(BERGER_CHECK_W-1){1'b0}}, ~d[i]};
        return {d, zeros};
    endfunction

endpackage

// File: rtl/berger_popcount8.sv
// Combinational ones-count of an 8-bit data byte (result 0..8).
module berger_popcount8
    import berger_pkg::*;
(
    input  logic [BERGER_DATA_W-1:0]  data,
    output logic [BERGER_CHECK_W-1:0] ones
);

    // Sum the set bits of the byte.
    always_comb begin
        ones = '0;
        for (int i = 0; i < BERGER_DATA_W; i++)
            ones = ones + {{(BERGER_CHECK_W-1){1'b0}}, data[i]};
    end

endmodule

// File: rtl/berger_code_checker.sv
// Two-stage Berger code checker with valid/ready handshake on both sides,
// a saturating error counter and an optional first-error log.
// Define BERGER_ERR_LOG_EN to build the first-error log; without it the
// first_err_* ports read as zero and no log state exists.
module berger_code_checker
    import berger_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [BERGER_CODE_W-1:0]    in_code,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [BERGER_DATA_W-1:0]    out_data,
    output logic                        out_err,
    output logic                        out_valid,
    input  logic                        out_ready,
    input  logic                        clr_count,
    output logic [BERGER_ERR_CNT_W-1:0] err_count,
    output logic                        first_err_valid,
    output logic [BERGER_CODE_W-1:0]    first_err_code
);

    // vld_pipe[1] = S1 occupied, vld_pipe[2] = S2 occupied
    logic [2:1]                vld_pipe;
    logic [BERGER_CODE_W-1:0]  s1_code;
    logic [BERGER_CHECK_W-1:0] s1_ones;
    berger_s2_t                s2_q;

    logic [BERGER_CHECK_W-1:0] in_ones;
    logic [BERGER_CHECK_W:0]   s1_sum;
    logic                      s1_err;
    logic                      s1_adv;
    logic                      s2_adv;
    logic                      err_xfer;

    // Ones-count is taken on the incoming word so S1 already holds it.
    berger_popcount8 u_popcount (
        .data (in_code[BERGER_CODE_W-1:BERGER_CHECK_W]),
        .ones (in_ones)
    );

    // Five-bit sum so an oversized check field can never wrap back to 8.
    assign s1_sum = {1'b0, s1_ones} + {1'b0, s1_code[BERGER_CHECK_W-1:0]};
    assign s1_err = (s1_code[BERGER_CHECK_W-1:0] > 4'd8) | (s1_sum != BERGER_SUM_OK);

    assign s2_adv   = !vld_pipe[2] | out_ready;
    assign s1_adv   = !vld_pipe[1] | s2_adv;
    // Gated by reset so nothing is offered as accepted while rst_n is low.
    assign in_ready = rst_n & s1_adv;

    assign out_valid = vld_pipe[2];
    assign out_data  = s2_q.data;
    assign out_err   = s2_q.err;
    assign err_xfer  = vld_pipe[2] & out_ready & s2_q.err;

    // Pipeline stages: each loads when empty or when its successor drains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_code  <= '0;
            s1_ones  <= '0;
            s2_q     <= '0;
        end else begin
            if (s1_adv) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) begin
                    s1_code <= in_code;
                    s1_ones <= in_ones;
                end
            end
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    s2_q.data <= s1_code[BERGER_CODE_W-1:BERGER_CHECK_W];
                    s2_q.err  <= s1_err;
                end
            end
        end
    end

    // Saturating count of errored output transfers; clear has priority.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_count)
            err_count <= '0;
        else if (err_xfer && (err_count != {BERGER_ERR_CNT_W{1'b1}}))
            err_count <= err_count + {{(BERGER_ERR_CNT_W-1){1'b0}}, 1'b1};
    end

`ifdef BERGER_ERR_LOG_EN
    logic [BERGER_CODE_W-1:0] s2_code;

    // Original code word travels alongside S2 so the log can capture it.
    always_ff @(posedge clk) begin
        if (!rst_n)
            s2_code <= '0;
        else if (s2_adv && vld_pipe[1])
            s2_code <= s1_code;
    end

    // Capture only the first errored transfer after reset or clear.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_count) begin
            first_err_valid <= 1'b0;
            first_err_code  <= '0;
        end else if (err_xfer && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_code  <= s2_code;
        end
    end
`else
    assign first_err_valid = 1'b0;
    assign first_err_code  = '0;
`endif

endmodule

// File: doc/berger_code_checker.md
BERGER_CODE_CHECKER -- requirements
Module: berger_code_checker

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 in_code  input  12  Berger code word; [11:4] data, [3:0] check field (8 minus ones-count of data).
REQ-004 in_valid  input  1  in_code valid this cycle.
REQ-005 in_ready  output  1  block accepts in_code this cycle; transfer = in_valid & in_ready.
REQ-006 out_data  output  8  recovered data bits [11:4] of the checked word.
REQ-007 out_err  output  1  checked word failed the Berger check.
REQ-008 out_valid  output  1  out_data/out_err valid.
REQ-009 out_ready  input  1  consumer accepts; transfer = out_valid & out_ready.
REQ-010 clr_count  input  1  synchronous clear of error statistics.
REQ-011 err_count  output  16  saturating count of errored output transfers.
REQ-012 first_err_valid  output  1  first-error log holds a captured word.
REQ-013 first_err_code  output  12  full code word of first errored output transfer.

Function
REQ-014 Pipeline SHALL have two registered stages: S1 = captured code word, S2 = data, error flag and original code word.
REQ-015 S1 SHALL compute ones = popcount(in_code[11:4]) (4-bit, 0..8); S2 error = (in_code[3:0] > 8) | (ones + check != 8), sum formed 5 bits wide, no truncation.
REQ-016 Latency SHALL be exactly 2 cycles from input transfer to out_valid with no backpressure; throughput one word per cycle.
REQ-017 Each stage SHALL advance when it is empty or its successor advances; in_ready = !S1_valid | S1 advancing; in_ready SHALL NOT depend on in_valid.
REQ-018 While out_valid & !out_ready, out_data, out_err and out_valid SHALL hold stable.
REQ-019 Full pipeline with out_ready low SHALL deassert in_ready; no word dropped or duplicated.
REQ-020 err_count SHALL increment by 1 per output transfer with out_err=1 and saturate at 0xFFFF.
REQ-021 clr_count=1 SHALL set err_count to 0 next cycle; clear wins over simultaneous increment.
REQ-022 Error counting SHALL never stall the data path; clr_count has no effect on pipeline contents.

Reset
REQ-023 rst_n=0 at a clock edge SHALL empty both stages: out_valid=0, in_ready=0 during reset, out_data=0, out_err=0.
REQ-024 Reset SHALL set err_count=0, first_err_valid=0, first_err_code=0.
REQ-025 Reset mid-operation SHALL discard in-flight words; in_ready=1 on the first cycle after rst_n returns high.

Configuration
REQ-026 Macro BERGER_ERR_LOG_EN SHALL compile in the first-error log.
REQ-027 With BERGER_ERR_LOG_EN: on the first errored output transfer while first_err_valid=0, capture the code word and set first_err_valid=1; later errors do not overwrite; clr_count clears both.
REQ-028 Without BERGER_ERR_LOG_EN: ports remain present, first_err_valid and first_err_code tied to 0, no log registers.

Structure
REQ-029 Shared package berger_pkg SHALL hold BERGER_DATA_W=8, BERGER_CHECK_W=4, BERGER_CODE_W=12 and BERGER_ERR_CNT_W=16; encoder and checker both use it.
REQ-030 Population count SHALL be one sub-module berger_popcount8 (8-bit in, 4-bit out, combinational).

Verification
REQ-031 in_code=0xA54, out_ready=1 -> 2 cycles later out_valid=1, out_data=0xA5, out_err=0, err_count unchanged.
REQ-032 in_code=0xA55 (single bit flip in check), then 0x254 (data bit 1->0) -> out_err=1 for both, err_count=2, first_err_code=0xA55 (macro on).
REQ-033 in_code=0x00F (check >8) -> out_err=1; in_code=0x008 -> out_err=0.
REQ-034 Stream 0x11 words back-to-back, out_ready low 5 cycles mid-stream -> outputs held stable, in_ready low once full, all words emerge in order, none lost.
REQ-035 Drive 65537 errored words -> err_count=0xFFFF; clr_count asserted in same cycle as an errored output transfer -> err_count=0, first_err_valid=0.
REQ-036 Assert rst_n=0 with two words in flight -> out_valid=0 next cycle, neither word ever appears; in_ready=1 first cycle after release.
